// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
//   Drives a 4-bit ALU one nibble per cycle, least-significant nibble first.
//   For arithmetic opcodes, each nibble's carry-out becomes the next nibble's
//   carry-in. The nibble results are collected into one wide response.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both 1. Once valid is high, the payload is held stable until that edge.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake. Payload: cmd_a, cmd_b, cmd_s, cmd_cin
//   alu_a/alu_b/alu_s/alu_carryin   slice driven to the ALU (0 outside RUN)
//   alu_y/alu_cout          combinational ALU result for the current slice
//   rsp_valid/rsp_ready     response handshake. Payload: rsp_y, rsp_cout
//   state_dbg               current FSM state (0 IDLE, 1 RUN, 2 DONE)
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [4*NIBBLES-1:0]   cmd_a,
    input  logic [4*NIBBLES-1:0]   cmd_b,
    input  logic [2:0]             cmd_s,
    input  logic                   cmd_cin,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [2:0]             alu_s,
    output logic                   alu_carryin,
    input  logic [3:0]             alu_y,
    input  logic                   alu_cout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_y,
    output logic                   rsp_cout,
    output logic [1:0]             state_dbg
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [2:0]      s_reg;
    logic            carry;
    logic [IW-1:0]   idx;
    logic [W-1:0]    result;
    logic            arith;

    // Opcodes 000 (add) and 001 (subtract) use the carry chain.
    assign arith = (s_reg[2:1] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            s_reg  <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        a_reg  <= cmd_a;
                        b_reg  <= cmd_b;
                        s_reg  <= cmd_s;
                        carry  <= cmd_cin;
                        idx    <= '0;
                        result <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    result[4*idx +: 4] <= alu_y;
                    carry <= arith ? alu_cout : 1'b0;
                    // idx stops at the last nibble. The next command clears it.
                    if (idx == LAST) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every output is decoded from registers only. No input passes
    // combinationally to an output.
    always_comb begin
        alu_a       = 4'd0;
        alu_b       = 4'd0;
        alu_s       = 3'd0;
        alu_carryin = 1'b0;
        if (state == RUN) begin
            alu_a       = a_reg[4*idx +: 4];
            alu_b       = b_reg[4*idx +: 4];
            alu_s       = s_reg;
            alu_carryin = arith & carry;
        end
    end

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign rsp_y     = result;
    assign rsp_cout  = carry;
    assign state_dbg = state;

endmodule
